// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage. Non-memory ops retire one
//               cycle after acceptance. Aligned lw/sw issue a single data
//               memory request held until acknowledged or timed out.
//               Misaligned lw/sw retire immediately with an error pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid_i             EX result present (sampled in IDLE only)
//   ALUop_i             5'b10100 = lw, 5'b10101 = sw, others non-memory
//   WriteReg_i          register-write enable
//   WriteDataNum_i      destination register index
//   WriteData_i         ALU / link result
//   MemAddr_i           effective address
//   StoreData_i         store operand
//   mem_ack_i           memory completes the access this cycle
//   mem_rdata_i         read data, valid with mem_ack_i
//   mem_req_o/mem_we_o  request / write strobe
//   mem_addr_o          word address
//   mem_wdata_o         store data (0 for lw)
//   stall_o             upstream holds while high (combinational from state)
//   valid_o, WriteReg_o, WriteDataNum_o, WriteData_o   retired result to WB
//   misalign_o, timeout_o                              one-cycle error pulses
// ============================================================================
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [4:0]  ALUop_i,
   input  logic        WriteReg_i,
   input  logic [4:0]  WriteDataNum_i,
   input  logic [31:0] WriteData_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] StoreData_i,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        stall_o,
   output logic        valid_o,
   output logic        WriteReg_o,
   output logic [4:0]  WriteDataNum_o,
   output logic [31:0] WriteData_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam logic [4:0] OP_LW     = 5'b10100;
   localparam logic [4:0] OP_SW     = 5'b10101;
   localparam logic [4:0] CNT_LIMIT = 5'd31;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        valid_q, valid_d;
   logic        wreg_q, wreg_d;
   logic [4:0]  num_q, num_d;
   logic [31:0] data_q, data_d;
   logic        mis_q, mis_d;
   logic        to_q, to_d;
   // Destination info of the in-flight access, needed at retirement.
   logic        cap_wreg_q, cap_wreg_d;
   logic [4:0]  cap_num_q, cap_num_d;

   logic        is_lw, is_sw;

   assign is_lw = (ALUop_i == OP_LW);
   assign is_sw = (ALUop_i == OP_SW);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      valid_d    = 1'b0;
      mis_d      = 1'b0;
      to_d       = 1'b0;
      wreg_d     = wreg_q;
      num_d      = num_q;
      data_d     = data_q;
      cap_wreg_d = cap_wreg_q;
      cap_num_d  = cap_num_q;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (is_lw || is_sw) begin
                  if (MemAddr_i[1:0] == 2'b00) begin
                     state_d    = ACCESS;
                     req_d      = 1'b1;
                     we_d       = is_sw;
                     addr_d     = MemAddr_i;
                     wdata_d    = is_sw ? StoreData_i : 32'd0;
                     cnt_d      = 5'd0;
                     cap_wreg_d = WriteReg_i;
                     cap_num_d  = WriteDataNum_i;
                  end else begin
                     // Misaligned: no request, retire at once as an error.
                     valid_d = 1'b1;
                     mis_d   = 1'b1;
                     wreg_d  = 1'b0;
                     num_d   = WriteDataNum_i;
                     data_d  = 32'd0;
                  end
               end else begin
                  valid_d = 1'b1;
                  wreg_d  = WriteReg_i;
                  num_d   = WriteDataNum_i;
                  data_d  = WriteData_i;
               end
            end
         end
         ACCESS: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (mem_ack_i) begin
               state_d = IDLE;
               req_d   = 1'b0;
               valid_d = 1'b1;
               num_d   = cap_num_q;
               if (we_q) begin
                  wreg_d = 1'b0;
                  data_d = 32'd0;
               end else begin
                  wreg_d = cap_wreg_q;
                  data_d = mem_rdata_i;
               end
            end else if (cnt_q == CNT_LIMIT) begin
               state_d = IDLE;
               req_d   = 1'b0;
               valid_d = 1'b1;
               to_d    = 1'b1;
               wreg_d  = 1'b0;
               num_d   = cap_num_q;
               data_d  = 32'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         valid_q    <= 1'b0;
         wreg_q     <= 1'b0;
         num_q      <= 5'd0;
         data_q     <= 32'd0;
         mis_q      <= 1'b0;
         to_q       <= 1'b0;
         cap_wreg_q <= 1'b0;
         cap_num_q  <= 5'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         valid_q    <= valid_d;
         wreg_q     <= wreg_d;
         num_q      <= num_d;
         data_q     <= data_d;
         mis_q      <= mis_d;
         to_q       <= to_d;
         cap_wreg_q <= cap_wreg_d;
         cap_num_q  <= cap_num_d;
      end
   end

   assign stall_o        = (state_q == ACCESS);
   assign mem_req_o      = req_q;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign valid_o        = valid_q;
   assign WriteReg_o     = wreg_q;
   assign WriteDataNum_o = num_q;
   assign WriteData_o    = data_q;
   assign misalign_o     = mis_q;
   assign timeout_o      = to_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. Expected retirements are
//               queued when an op is driven and compared when valid_o rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [4:0]  ALUop_i = 5'd0;
   logic        WriteReg_i = 1'b0;
   logic [4:0]  WriteDataNum_i = 5'd0;
   logic [31:0] WriteData_i = 32'd0;
   logic [31:0] MemAddr_i = 32'd0;
   logic [31:0] StoreData_i = 32'd0;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'd0;
   logic        mem_req_o, mem_we_o, stall_o, valid_o, WriteReg_o;
   logic        misalign_o, timeout_o;
   logic [31:0] mem_addr_o, mem_wdata_o, WriteData_o;
   logic [4:0]  WriteDataNum_o;

   localparam logic [4:0] OP_LW  = 5'b10100;
   localparam logic [4:0] OP_SW  = 5'b10101;
   localparam logic [4:0] OP_ADD = 5'b01101;

   typedef struct packed {
      logic        wr;
      logic [4:0]  num;
      logic [31:0] data;
      logic        mis;
      logic        to;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   retired = 0;
   bit   mon_en = 1'b0;

   mem_access dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ALUop_i(ALUop_i),
      .WriteReg_i(WriteReg_i), .WriteDataNum_i(WriteDataNum_i),
      .WriteData_i(WriteData_i), .MemAddr_i(MemAddr_i),
      .StoreData_i(StoreData_i), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .stall_o(stall_o),
      .valid_o(valid_o), .WriteReg_o(WriteReg_o),
      .WriteDataNum_o(WriteDataNum_o), .WriteData_o(WriteData_o),
      .misalign_o(misalign_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic wr, input logic [4:0] num,
                        input logic [31:0] wd, input logic [31:0] addr, input logic [31:0] sd);
      valid_i        = 1'b1;
      ALUop_i        = op;
      WriteReg_i     = wr;
      WriteDataNum_i = num;
      WriteData_i    = wd;
      MemAddr_i      = addr;
      StoreData_i    = sd;
   endtask

   task automatic push(input logic wr, input logic [4:0] num, input logic [31:0] data,
                       input logic mis, input logic to);
      exp_t e;
      e.wr = wr; e.num = num; e.data = data; e.mis = mis; e.to = to;
      q.push_back(e);
   endtask

   // Retirement monitor: compares every valid_o against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         if (valid_o === 1'b1) begin
            retired++;
            if (q.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("ret_wreg", {31'd0, WriteReg_o}, {31'd0, e.wr});
               chk("ret_num", {27'd0, WriteDataNum_o}, {27'd0, e.num});
               chk("ret_data", WriteData_o, e.data);
               chk("ret_mis", {31'd0, misalign_o}, {31'd0, e.mis});
               chk("ret_to", {31'd0, timeout_o}, {31'd0, e.to});
            end
         end else begin
            chk("idle_mis", {31'd0, misalign_o}, 32'd0);
            chk("idle_to", {31'd0, timeout_o}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      // ---------------- reset ----------------
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_data", WriteData_o, 32'd0);
      mon_en = 1'b1;

      // ---------------- add: 1-cycle retire ----------------
      drive(OP_ADD, 1'b1, 5'd3, 32'h0000_0005, 32'h0, 32'h0);
      push(1'b1, 5'd3, 32'h0000_0005, 1'b0, 1'b0);
      chk("add_stall0", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("add_valid", {31'd0, valid_o}, 32'd1);
      chk("add_stall1", {31'd0, stall_o}, 32'd0);
      chk("add_req", {31'd0, mem_req_o}, 32'd0);
      @(negedge clk);

      // ---------------- lw 0x100, ack in 4th ACCESS cycle ----------------
      drive(OP_LW, 1'b1, 5'd7, 32'h0, 32'h0000_0100, 32'hFFFF_FFFF);
      push(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("lw_req", {31'd0, mem_req_o}, 32'd1);
         chk("lw_stall", {31'd0, stall_o}, 32'd1);
         chk("lw_addr", mem_addr_o, 32'h0000_0100);
         chk("lw_we", {31'd0, mem_we_o}, 32'd0);
         chk("lw_wdata", mem_wdata_o, 32'd0);
         if (i == 3) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hDEAD_BEEF;
         end
         @(negedge clk);
      end
      mem_ack_i = 1'b0;
      chk("lw_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("lw_stall_drop", {31'd0, stall_o}, 32'd0);
      chk("lw_valid", {31'd0, valid_o}, 32'd1);
      @(negedge clk);
      chk("lw_valid_1cyc", {31'd0, valid_o}, 32'd0);

      // ---------------- sw 0x204 immediate ack ----------------
      drive(OP_SW, 1'b1, 5'd9, 32'h0, 32'h0000_0204, 32'h1234_5678);
      push(1'b0, 5'd9, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("sw_req", {31'd0, mem_req_o}, 32'd1);
      chk("sw_we", {31'd0, mem_we_o}, 32'd1);
      chk("sw_addr", mem_addr_o, 32'h0000_0204);
      chk("sw_wdata", mem_wdata_o, 32'h1234_5678);
      chk("sw_stall", {31'd0, stall_o}, 32'd1);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("sw_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("sw_valid", {31'd0, valid_o}, 32'd1);
      @(negedge clk);

      // ---------------- misaligned lw 0x102 ----------------
      drive(OP_LW, 1'b1, 5'd4, 32'h0, 32'h0000_0102, 32'h0);
      push(1'b0, 5'd4, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("mis_req", {31'd0, mem_req_o}, 32'd0);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      @(negedge clk);
      chk("mis_req2", {31'd0, mem_req_o}, 32'd0);
      chk("mis_valid_1cyc", {31'd0, valid_o}, 32'd0);

      // ---------------- lw with no ack: timeout after 32 ACCESS cycles -------
      drive(OP_LW, 1'b1, 5'd11, 32'h0, 32'h0000_0040, 32'h0);
      push(1'b0, 5'd11, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      valid_i = 1'b0;
      n = 0;
      while (stall_o === 1'b1 && n < 40) begin
         if (mem_req_o !== 1'b1) chk("to_req_held", {31'd0, mem_req_o}, 32'd1);
         n++;
         @(negedge clk);
      end
      chk("to_access_cycles", n, 32'd32);
      chk("to_pulse", {31'd0, timeout_o}, 32'd1);
      chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("to_idle", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      chk("to_pulse_1cyc", {31'd0, timeout_o}, 32'd0);

      // ---------------- ack coinciding with count 31: ack wins ----------------
      drive(OP_LW, 1'b1, 5'd12, 32'h0, 32'h0000_0300, 32'h0);
      push(1'b1, 5'd12, 32'hCAFE_0031, 1'b0, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (stall_o !== 1'b1) chk("late_ack_stall", {31'd0, stall_o}, 32'd1);
         if (i == 31) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hCAFE_0031;
         end
         @(negedge clk);
      end
      mem_ack_i = 1'b0;
      chk("late_ack_valid", {31'd0, valid_o}, 32'd1);
      chk("late_ack_stall_drop", {31'd0, stall_o}, 32'd0);
      @(negedge clk);

      // ---------------- reset in 2nd ACCESS cycle ----------------
      drive(OP_LW, 1'b1, 5'd5, 32'h0, 32'h0000_0080, 32'h0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("rsta_req1", {31'd0, mem_req_o}, 32'd1);
      @(negedge clk);
      chk("rsta_stall2", {31'd0, stall_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h5555_AAAA;
      chk("rsta_req", {31'd0, mem_req_o}, 32'd0);
      chk("rsta_stall", {31'd0, stall_o}, 32'd0);
      chk("rsta_valid", {31'd0, valid_o}, 32'd0);
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("rsta_valid2", {31'd0, valid_o}, 32'd0);
      chk("rsta_addr", mem_addr_o, 32'd0);
      chk("rsta_data", WriteData_o, 32'd0);
      chk("rsta_num", {27'd0, WriteDataNum_o}, 32'd0);
      drive(OP_ADD, 1'b1, 5'd2, 32'h0000_00A5, 32'h0, 32'h0);
      push(1'b1, 5'd2, 32'h0000_00A5, 1'b0, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("rsta_next_valid", {31'd0, valid_o}, 32'd1);
      repeat (3) @(negedge clk);

      chk("sb_empty", q.size(), 32'd0);
      chk("retire_count", retired, 32'd7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
